sha256_multiblock_ctrl: RTL
===========================

# sha256_multiblock_ctrl

Sequencer that extends the single-block `SHA256top` core to messages of any number of 512-bit blocks. It accepts pre-padded blocks over a valid/ready stream and drives the core's level-held `start_in`/`sha256_done` handshake for each block. It chains each intermediate digest into the core's `A_i..H_i` inputs and presents the final digest on a valid/ready output. It sits between the message-padding front end and one `SHA256top` instance, which the parent module instantiates.

## Interface
- `TIMEOUT_CYCLES`, 256: max cycles in RUN without `core_done`; on expiry, abort with error.
- `CNT_W`, 16: width of `blk_count`.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `blk_valid` in 1: input block valid.
- `blk_ready` out 1: block accepted on `blk_valid && blk_ready`.
- `blk_data` in 512: padded block; [511:480]=w0 … [31:0]=w15.
- `blk_last` in 1: final block of message, qualified with `blk_valid`.
- `core_start` out 1: drives `SHA256top.start_in`.
- `core_w` out 512: drives w0..w15, same packing as `blk_data`.
- `core_h` out 256: drives A_i..H_i; [255:224]=A_i.
- `core_result` in 256: `SHA256top.sha256_result`.
- `core_done` in 1: `SHA256top.sha256_done`.
- `digest` out 256: final hash.
- `digest_valid` out 1: digest available; held until accepted.
- `digest_ready` in 1: consumer accepts when high with `digest_valid`.
- `busy` out 1: high in any state except IDLE.
- `error` out 1: sticky core-timeout flag; cleared only by reset or acceptance of the next first block.
- `blk_count` out CNT_W: blocks completed in current message; wraps modulo 2^CNT_W.

## Operation
- States: IDLE, RUN, RELEASE, WAIT_BLK, OUT.
- IDLE: `blk_ready`=1. On accept: latch block into `core_w`; load `h_reg`=IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19); clear `blk_count` and `error`; latch `last_q`=`blk_last`; go to RUN.
- RUN: `core_start`=1, `core_h`=`h_reg`. When `core_done`=1: `h_reg`←`core_result`, `blk_count`+1, go to RELEASE. Watchdog counts RUN cycles. At TIMEOUT_CYCLES: set `error`, drop start, go to IDLE without producing a digest.
- RELEASE: `core_start`=0. Wait for `core_done`=0. Then go to OUT if `last_q`, else WAIT_BLK.
- WAIT_BLK: `blk_ready`=1. On accept: latch block and `last_q`, keep `h_reg`, go to RUN.
- OUT: `digest`=`h_reg`, `digest_valid`=1, `blk_ready`=0. On `digest_ready`, go to IDLE.
- `core_h` is always IV-based or chained and is never all-zero by design. The controller never relies on the core's zero-default IV.
- `blk_ready` is 0 in RUN, RELEASE and OUT. Blocks presented then are stalled, not dropped.
- `core_w`, `core_h` and `h_reg` are stable for the whole of RUN.

## Timing
- Reset values: `blk_ready`=0 during reset and 1 from the first cycle after deassertion (IDLE). All other outputs are 0. State=IDLE; `core_w`, `h_reg` and `digest` are 0.
- Reset asserted mid-operation: `core_start` falls asynchronously, the partial message is discarded, and no digest is produced.
- Accept edge N: `core_start`=1 from N+1.
- `core_done` first sampled high at edge M: `core_start`=0 from M+1.
- `core_done` sampled low at edge R: `blk_ready` (WAIT_BLK) or `digest_valid` (OUT) rises at R+1.
- Per-block overhead beyond core latency: 3 cycles.
- `digest_valid` and `digest_ready` both high at an edge: accepted; `blk_ready`=1 the next cycle.
- `blk_last`=1 on the first block: single-block message.
- `blk_count` at 2^CNT_W−1 wraps to 0 with no error.
- Timeout is checked only in RUN. A `core_done` that arrives after a timeout is ignored; RELEASE-like cleanup is not required because `core_start` is already low.

## Structure
- `sha256_pkg` holds:
  - SHA-256 IV constants as one 256-bit localparam.
  - State enum.
  - Block and digest width constants (512, 256).
- One sub-module: `sha256_core_watchdog`, a cycle counter with `clear`, `enable` and `expired` ports, sized by TIMEOUT_CYCLES.
- The FSM, `h_reg` and block latch live in the top level.

## Test plan
- Single block "abc": w0=61626380, w15=00000018, `blk_last`=1 -> digest ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, `blk_count`=1.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", 448 bits:
  - Block 1 = message with w14=80000000, w15=0.
  - Block 2 = zeros with w15=000001C0 and `blk_last`=1.
  - Expect digest 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1, `blk_count`=2.
  - Check that block 2's `core_h` equals block 1's `core_result`.
- Back-to-back messages "abc" then "" (w0=80000000) with `digest_ready` held low 10 cycles:
  - `digest_valid` holds with stable value and `blk_ready`=0 while stalled.
  - Second digest e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855, i.e. IV reloaded.
- Stub core that never asserts `core_done`, TIMEOUT_CYCLES=16 -> `error`=1 after 16 RUN cycles, `core_start`=0, IDLE, no `digest_valid`. A following "abc" clears `error` and yields the correct digest.
- `reset` low mid-RUN of a two-block message -> all outputs 0 immediately. After release, "a" (w0=61800000, w15=00000008) -> ca978112ca1bbdcafac231b39a23dc4da786eff8147c4e72b9807785afee48bb.

Source files
------------

// File: rtl/sha256_multiblock_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// sha256_pkg: shared widths, IV and controller state encoding
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sha256_pkg;

  localparam int c_blk_w = 512;
  localparam int c_dig_w = 256;

  localparam logic [c_dig_w-1:0] c_sha256_iv =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_RELEASE  = 3'd2,
    ST_WAIT_BLK = 3'd3,
    ST_OUT      = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sha256_multiblock_ctrl_if.sv
// ----------------------------------------------------------------------------
// sha256_multiblock_ctrl_if: block stream, core handshake and digest stream
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface sha256_multiblock_ctrl_if;
  import sha256_pkg::*;

  logic               blk_valid;
  logic               blk_ready;
  logic [c_blk_w-1:0] blk_data;
  logic               blk_last;

  logic               core_start;
  logic [c_blk_w-1:0] core_w;
  logic [c_dig_w-1:0] core_h;
  logic [c_dig_w-1:0] core_result;
  logic               core_done;

  logic [c_dig_w-1:0] digest;
  logic               digest_valid;
  logic               digest_ready;

  // slave: the controller's view
  modport slave (
    input  blk_valid, blk_data, blk_last, core_result, core_done, digest_ready,
    output blk_ready, core_start, core_w, core_h, digest, digest_valid
  );

  modport master (
    output blk_valid, blk_data, blk_last, core_result, core_done, digest_ready,
    input  blk_ready, core_start, core_w, core_h, digest, digest_valid
  );

endinterface

`default_nettype wire

// File: rtl/sha256_multiblock_ctrl_watchdog.sv
// ----------------------------------------------------------------------------
// sha256_core_watchdog: counts enabled cycles, flags the last allowed one
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sha256_core_watchdog #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic clear,
  input  wire logic enable,
  output logic      expired
);

  localparam int c_cnt_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

  logic [c_cnt_w-1:0] r_cnt;

  // Asserted during the final permitted cycle so the owner can leave on that edge
  assign expired = enable && (r_cnt == c_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable && !expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sha256_multiblock_ctrl.sv
// ----------------------------------------------------------------------------
// sha256_multiblock_ctrl: sequences padded blocks through one SHA256top core
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sha256_multiblock_ctrl
  import sha256_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 16
) (
  input  wire logic          clk,
  input  wire logic          reset,
  sha256_multiblock_ctrl_if.slave bus,
  output logic               busy,
  output logic               error,
  output logic [CNT_W-1:0]   blk_count
);

  state_t             r_state;
  state_t             w_next;
  logic               r_live;
  logic [c_blk_w-1:0] r_blk;
  logic [c_dig_w-1:0] r_h;
  logic               r_last;
  logic               r_err;
  logic [CNT_W-1:0]   r_blk_cnt;
  logic               w_accept;
  logic               w_expired;

  assign w_accept  = bus.blk_valid && bus.blk_ready;
  assign bus.core_w = r_blk;
  assign bus.core_h = r_h;
  assign error     = r_err;
  assign blk_count = r_blk_cnt;

  sha256_core_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (r_state != ST_RUN),
    .enable (r_state == ST_RUN),
    .expired(w_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next           = r_state;
    bus.blk_ready    = 1'b0;
    bus.core_start   = 1'b0;
    bus.digest_valid = 1'b0;
    bus.digest       = '0;
    busy             = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy          = 1'b0;
        bus.blk_ready = r_live;
        if (w_accept) w_next = ST_RUN;
      end
      ST_RUN: begin
        bus.core_start = 1'b1;
        if (bus.core_done)  w_next = ST_RELEASE;
        else if (w_expired) w_next = ST_IDLE;
      end
      ST_RELEASE: begin
        if (!bus.core_done) w_next = r_last ? ST_OUT : ST_WAIT_BLK;
      end
      ST_WAIT_BLK: begin
        bus.blk_ready = r_live;
        if (w_accept) w_next = ST_RUN;
      end
      ST_OUT: begin
        bus.digest_valid = 1'b1;
        bus.digest       = r_h;
        if (bus.digest_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // r_live holds blk_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_live    <= 1'b0;
      r_blk     <= '0;
      r_h       <= '0;
      r_last    <= 1'b0;
      r_err     <= 1'b0;
      r_blk_cnt <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_accept) begin
        r_blk  <= bus.blk_data;
        r_last <= bus.blk_last;
        if (r_state == ST_IDLE) begin
          r_h       <= c_sha256_iv;
          r_blk_cnt <= '0;
          r_err     <= 1'b0;
        end
      end
      if (r_state == ST_RUN) begin
        if (bus.core_done) begin
          r_h       <= bus.core_result;
          r_blk_cnt <= r_blk_cnt + 1'b1;
        end else if (w_expired) begin
          r_err <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire
